// File: rtl/miriscv_lsu_split.sv
// Load/store unit with a request/grant/response memory handshake.
// Misaligned halfword and word accesses can be split into two aligned word transactions.
module miriscv_lsu_split #(
  parameter bit MISALIGN_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        arstn_i,
  input  logic [31:0] lsu_addr_i,
  input  logic        lsu_we_i,
  input  logic [2:0]  lsu_size_i,
  input  logic [31:0] lsu_data_i,
  input  logic        lsu_req_i,
  output logic        lsu_stall_req_o,
  output logic [31:0] lsu_data_o,
  output logic        lsu_fault_o,
  output logic        data_req_o,
  input  logic        data_gnt_i,
  input  logic        data_rvalid_i,
  input  logic [31:0] data_rdata_i,
  output logic        data_we_o,
  output logic [3:0]  data_be_o,
  output logic [31:0] data_addr_o,
  output logic [31:0] data_wdata_o
);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ADDR1 = 3'd1,
    RESP1 = 3'd2,
    ADDR2 = 3'd3,
    RESP2 = 3'd4,
    DONE  = 3'd5
  } state_t;

  state_t      state_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [31:0] lo_reg;
  logic        we_reg;
  logic [2:0]  size_reg;
  logic [3:0]  be_hi_reg;

  logic [1:0]  off_in;
  logic [3:0]  mask_in;
  logic [7:0]  ext_in;
  logic        size_ok_in;
  logic        misaligned_in;
  logic        fault_in;

  always_comb begin
    off_in = lsu_addr_i[1:0];
    case (lsu_size_i[1:0])
      2'b00:   mask_in = 4'b0001;
      2'b01:   mask_in = 4'b0011;
      default: mask_in = 4'b1111;
    endcase
    ext_in        = {4'b0000, mask_in} << off_in;
    size_ok_in    = lsu_size_i inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    misaligned_in = ((lsu_size_i[1:0] == 2'b01) && off_in[0]) ||
                    ((lsu_size_i[1:0] == 2'b10) && (off_in != 2'b00));
    fault_in      = !size_ok_in || (!MISALIGN_EN && misaligned_in);
  end

  logic [1:0]  off_reg;
  logic        split_reg;
  logic [63:0] resp_cat;
  logic [31:0] resp_shift;
  logic [31:0] load_val;
  logic [5:0]  hi_shamt;
  logic [31:0] wdata_hi;

  assign off_reg   = addr_reg[1:0];
  assign split_reg = |be_hi_reg;
  assign hi_shamt  = 6'd32 - {1'b0, off_reg, 3'b000};
  assign wdata_hi  = wdata_reg >> hi_shamt;

  // In RESP1 of a non-split access the upper word is never selected, so zero is a safe filler.
  always_comb begin
    resp_cat   = (state_reg == RESP2) ? {data_rdata_i, lo_reg} : {32'h0000_0000, data_rdata_i};
    resp_shift = resp_cat[{off_reg, 3'b000} +: 32];
    case (size_reg)
      3'b000:  load_val = {{24{resp_shift[7]}}, resp_shift[7:0]};
      3'b001:  load_val = {{16{resp_shift[15]}}, resp_shift[15:0]};
      3'b100:  load_val = {24'h000000, resp_shift[7:0]};
      3'b101:  load_val = {16'h0000, resp_shift[15:0]};
      default: load_val = resp_shift;
    endcase
  end

  assign lsu_stall_req_o = lsu_req_i && (state_reg != DONE);

  always_ff @(posedge clk_i) begin
    if (arstn_i) begin
      state_reg    <= IDLE;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      lo_reg       <= '0;
      we_reg       <= 1'b0;
      size_reg     <= '0;
      be_hi_reg    <= '0;
      data_req_o   <= 1'b0;
      data_we_o    <= 1'b0;
      data_be_o    <= '0;
      data_addr_o  <= '0;
      data_wdata_o <= '0;
      lsu_data_o   <= '0;
      lsu_fault_o  <= 1'b0;
    end else begin
      lsu_fault_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (lsu_req_i) begin
            addr_reg  <= lsu_addr_i;
            we_reg    <= lsu_we_i;
            size_reg  <= lsu_size_i;
            wdata_reg <= lsu_data_i;
            be_hi_reg <= ext_in[7:4];
            if (fault_in) begin
              state_reg   <= DONE;
              lsu_fault_o <= 1'b1;
            end else begin
              state_reg    <= ADDR1;
              data_req_o   <= 1'b1;
              data_we_o    <= lsu_we_i;
              data_be_o    <= ext_in[3:0];
              data_addr_o  <= {lsu_addr_i[31:2], 2'b00};
              data_wdata_o <= lsu_data_i << {off_in, 3'b000};
            end
          end
        end
        ADDR1: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_reg  <= RESP1;
          end
        end
        RESP1: begin
          if (data_rvalid_i) begin
            lo_reg <= data_rdata_i;
            if (split_reg) begin
              state_reg    <= ADDR2;
              data_req_o   <= 1'b1;
              data_be_o    <= be_hi_reg;
              data_addr_o  <= {addr_reg[31:2], 2'b00} + 32'd4;
              data_wdata_o <= wdata_hi;
            end else begin
              state_reg <= DONE;
              if (!we_reg) lsu_data_o <= load_val;
            end
          end
        end
        ADDR2: begin
          if (data_gnt_i) begin
            data_req_o <= 1'b0;
            state_reg  <= RESP2;
          end
        end
        RESP2: begin
          if (data_rvalid_i) begin
            state_reg <= DONE;
            if (!we_reg) lsu_data_o <= load_val;
          end
        end
        DONE:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_miriscv_lsu_split.sv
// Scoreboard bench: stimulus queues expected memory transactions and load results,
// independent monitors compare them against what the two DUT instances present.
module tb_miriscv_lsu_split;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Instance A: splitting enabled, driven by a behavioural memory
  logic [31:0] a_addr, a_wdata, a_rdata_o;
  logic        a_we, a_req, a_stall, a_fault;
  logic [2:0]  a_size;
  logic        m_req, m_gnt, m_rvalid, m_we;
  logic [31:0] m_rdata, m_addr, m_wdata;
  logic [3:0]  m_be;

  // Instance B: splitting disabled, memory always ready
  logic [31:0] b_addr, b_wdata, b_rdata_o;
  logic        b_we, b_req, b_stall, b_fault;
  logic [2:0]  b_size;
  logic        bm_req, bm_we;
  logic [31:0] bm_addr, bm_wdata;
  logic [3:0]  bm_be;

  miriscv_lsu_split #(.MISALIGN_EN(1'b1)) dut_a (
    .clk_i(clk), .arstn_i(rst),
    .lsu_addr_i(a_addr), .lsu_we_i(a_we), .lsu_size_i(a_size), .lsu_data_i(a_wdata),
    .lsu_req_i(a_req), .lsu_stall_req_o(a_stall), .lsu_data_o(a_rdata_o), .lsu_fault_o(a_fault),
    .data_req_o(m_req), .data_gnt_i(m_gnt), .data_rvalid_i(m_rvalid), .data_rdata_i(m_rdata),
    .data_we_o(m_we), .data_be_o(m_be), .data_addr_o(m_addr), .data_wdata_o(m_wdata)
  );

  miriscv_lsu_split #(.MISALIGN_EN(1'b0)) dut_b (
    .clk_i(clk), .arstn_i(rst),
    .lsu_addr_i(b_addr), .lsu_we_i(b_we), .lsu_size_i(b_size), .lsu_data_i(b_wdata),
    .lsu_req_i(b_req), .lsu_stall_req_o(b_stall), .lsu_data_o(b_rdata_o), .lsu_fault_o(b_fault),
    .data_req_o(bm_req), .data_gnt_i(1'b1), .data_rvalid_i(1'b1), .data_rdata_i(32'h5A5A5A5A),
    .data_we_o(bm_we), .data_be_o(bm_be), .data_addr_o(bm_addr), .data_wdata_o(bm_wdata)
  );

  typedef struct {
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
  } txn_t;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    int          lat;
    int          issue;
  } res_t;

  txn_t txn_q[$];
  res_t res_a_q[$];
  res_t res_b_q[$];

  int checks = 0;
  int fails  = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    case (a)
      32'h0000_0100: return 32'hDEADBEEF;
      32'h0000_0200: return 32'h80112233;
      32'h0FFF_FFFC: return 32'h12345678;
      32'h1000_0000: return 32'hABCDEF80;
      default:       return 32'h0000_0000;
    endcase
  endfunction

  // Memory responder for instance A with programmable grant/response delays
  int   gnt_delay = 0, rvalid_delay = 0, gnt_wait = 0, rsp_wait = 0;
  bit   rsp_pending = 1'b0;
  logic [31:0] rsp_addr;

  initial begin
    m_gnt = 1'b0; m_rvalid = 1'b0; m_rdata = '0; rsp_addr = '0;
    forever begin
      @(negedge clk);
      m_gnt = 1'b0;
      m_rvalid = 1'b0;
      if (rsp_pending) begin
        if (rsp_wait == 0) begin
          m_rvalid = 1'b1;
          m_rdata = mem_rd(rsp_addr);
          rsp_pending = 1'b0;
        end else rsp_wait--;
      end else if (m_req) begin
        if (gnt_wait == 0) begin
          m_gnt = 1'b1;
          rsp_pending = 1'b1;
          rsp_wait = rvalid_delay;
          rsp_addr = m_addr;
          gnt_wait = gnt_delay;
        end else gnt_wait--;
      end
    end
  end

  // Transaction monitor: compares every cycle a request is held, so stability is checked too
  txn_t cur;
  bit   txn_active = 1'b0;
  always @(negedge clk) begin
    logic [31:0] wm;
    if (m_req) begin
      chk("stall_while_req", {31'b0, a_stall}, 32'd1);
      if (!txn_active) begin
        if (txn_q.size() == 0) begin
          checks++; fails++;
          $display("FAIL unexpected_txn: got addr %h be %b, required no request", m_addr, m_be);
        end else begin
          cur = txn_q.pop_front();
          txn_active = 1'b1;
        end
      end
      if (txn_active) begin
        for (int i = 0; i < 4; i++) wm[8*i +: 8] = {8{cur.be[i]}};
        chk("txn_addr", m_addr, cur.addr);
        chk("txn_be", {28'b0, m_be}, {28'b0, cur.be});
        chk("txn_we", {31'b0, m_we}, {31'b0, cur.we});
        if (cur.we) chk("txn_wdata", m_wdata & wm, cur.wdata & wm);
      end
    end else begin
      txn_active = 1'b0;
    end
  end

  // Result monitors: DONE is seen as a request with stall released
  always @(negedge clk) begin
    res_t r;
    if (a_req && !a_stall) begin
      if (res_a_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL a_unexpected_done: got data %h, required no completion", a_rdata_o);
      end else begin
        r = res_a_q.pop_front();
        chk("a_lsu_data", a_rdata_o, r.data);
        chk("a_fault", {31'b0, a_fault}, {31'b0, r.fault});
        if (r.lat >= 0) chk("a_latency", cyc - r.issue, r.lat);
        $display("A done: data %h fault %0d after %0d cycles", a_rdata_o, a_fault, cyc - r.issue);
      end
    end
  end

  always @(negedge clk) begin
    res_t r;
    if (b_req) chk("b_no_mem_req", {31'b0, bm_req}, 32'd0);
    if (b_req && !b_stall) begin
      if (res_b_q.size() == 0) begin
        checks++; fails++;
        $display("FAIL b_unexpected_done: got data %h, required no completion", b_rdata_o);
      end else begin
        r = res_b_q.pop_front();
        chk("b_lsu_data", b_rdata_o, r.data);
        chk("b_fault", {31'b0, b_fault}, {31'b0, r.fault});
        chk("b_latency", cyc - r.issue, r.lat);
        $display("B done: data %h fault %0d after %0d cycles", b_rdata_o, b_fault, cyc - r.issue);
      end
    end
  end

  task automatic exp_txn(input logic [31:0] addr, input logic [3:0] be, input logic we,
                         input logic [31:0] wdata);
    txn_t t;
    t.addr = addr; t.be = be; t.we = we; t.wdata = wdata;
    txn_q.push_back(t);
  endtask

  task automatic acc_a(input logic [31:0] addr, input logic we, input logic [2:0] size,
                       input logic [31:0] data, input logic [31:0] exp, input logic expf,
                       input int lat);
    res_t r;
    bit done = 1'b0;
    @(posedge clk); #1;
    r.data = exp; r.fault = expf; r.lat = lat; r.issue = cyc;
    res_a_q.push_back(r);
    a_addr = addr; a_we = we; a_size = size; a_wdata = data; a_req = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      @(negedge clk);
      if (!a_stall) done = 1'b1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL a_timeout: got no completion for addr %h, required one within 60 cycles", addr);
    end
    @(posedge clk); #1;
    a_req = 1'b0;
  endtask

  task automatic acc_b(input logic [31:0] addr, input logic [2:0] size, input logic [31:0] exp);
    res_t r;
    bit done = 1'b0;
    @(posedge clk); #1;
    r.data = exp; r.fault = 1'b1; r.lat = 1; r.issue = cyc;
    res_b_q.push_back(r);
    b_addr = addr; b_we = 1'b0; b_size = size; b_wdata = 32'h0; b_req = 1'b1;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (!b_stall) done = 1'b1;
    end
    if (!done) begin
      checks++; fails++;
      $display("FAIL b_timeout: got no completion for addr %h, required one within 20 cycles", addr);
    end
    @(posedge clk); #1;
    b_req = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, required completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    a_addr = '0; a_we = 1'b0; a_size = '0; a_wdata = '0; a_req = 1'b0;
    b_addr = '0; b_we = 1'b0; b_size = '0; b_wdata = '0; b_req = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_data_req", {31'b0, m_req}, 32'd0);
    chk("rst_data_we", {31'b0, m_we}, 32'd0);
    chk("rst_data_be", {28'b0, m_be}, 32'd0);
    chk("rst_data_addr", m_addr, 32'd0);
    chk("rst_data_wdata", m_wdata, 32'd0);
    chk("rst_lsu_data", a_rdata_o, 32'd0);
    chk("rst_lsu_fault", {31'b0, a_fault}, 32'd0);
    chk("rst_stall", {31'b0, a_stall}, 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Aligned and sub-word loads, zero-wait memory
    exp_txn(32'h100, 4'b1111, 1'b0, 32'h0);
    acc_a(32'h100, 1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 3);
    exp_txn(32'h200, 4'b1000, 1'b0, 32'h0);
    acc_a(32'h203, 1'b0, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 3);
    exp_txn(32'h200, 4'b1000, 1'b0, 32'h0);
    acc_a(32'h203, 1'b0, 3'b100, 32'h0, 32'h00000080, 1'b0, 3);

    // Split store: result register holds the previous load value
    exp_txn(32'h100, 4'b1110, 1'b1, 32'hBBCCDD00);
    exp_txn(32'h104, 4'b0001, 1'b1, 32'h000000AA);
    acc_a(32'h101, 1'b1, 3'b010, 32'hAABBCCDD, 32'h00000080, 1'b0, 5);

    // Split halfword load across a word boundary
    exp_txn(32'h0FFFFFFC, 4'b1000, 1'b0, 32'h0);
    exp_txn(32'h10000000, 4'b0001, 1'b0, 32'h0);
    acc_a(32'h0FFFFFFF, 1'b0, 3'b001, 32'h0, 32'hFFFF8012, 1'b0, 5);

    exp_txn(32'h100, 4'b1100, 1'b0, 32'h0);
    acc_a(32'h102, 1'b0, 3'b101, 32'h0, 32'h0000DEAD, 1'b0, 3);

    // Split store whose second word wraps to address zero
    exp_txn(32'hFFFFFFFC, 4'b1100, 1'b1, 32'h33440000);
    exp_txn(32'h00000000, 4'b0011, 1'b1, 32'h00001122);
    acc_a(32'hFFFFFFFE, 1'b1, 3'b010, 32'h11223344, 32'h0000DEAD, 1'b0, 5);

    // Invalid sizes fault without a memory access
    acc_a(32'h100, 1'b0, 3'b011, 32'h0, 32'h0000DEAD, 1'b1, 1);
    acc_a(32'h104, 1'b1, 3'b111, 32'h12345678, 32'h0000DEAD, 1'b1, 1);

    exp_txn(32'h100, 4'b0100, 1'b1, 32'h00EE0000);
    acc_a(32'h102, 1'b1, 3'b000, 32'h000000EE, 32'h0000DEAD, 1'b0, 3);

    // Slow memory: grant withheld 3 cycles, response 2 cycles late
    gnt_delay = 3; gnt_wait = 3; rvalid_delay = 2;
    exp_txn(32'h100, 4'b1111, 1'b0, 32'h0);
    acc_a(32'h100, 1'b0, 3'b010, 32'h0, 32'hDEADBEEF, 1'b0, 8);

    // Reset during RESP1; the late response must be ignored
    gnt_delay = 0; gnt_wait = 0; rvalid_delay = 5;
    exp_txn(32'h200, 4'b1111, 1'b0, 32'h0);
    @(posedge clk); #1;
    a_addr = 32'h200; a_we = 1'b0; a_size = 3'b010; a_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; a_req = 1'b0;
    @(negedge clk);
    chk("rst_mid_data_req", {31'b0, m_req}, 32'd0);
    chk("rst_mid_stall", {31'b0, a_stall}, 32'd0);
    chk("rst_mid_lsu_data", a_rdata_o, 32'd0);
    chk("rst_mid_fault", {31'b0, a_fault}, 32'd0);
    repeat (10) @(posedge clk);
    rvalid_delay = 0;
    exp_txn(32'h200, 4'b1000, 1'b0, 32'h0);
    acc_a(32'h203, 1'b0, 3'b000, 32'h0, 32'hFFFFFF80, 1'b0, 3);

    // Splitting disabled: misaligned and invalid accesses fault at cycle 1
    acc_b(32'h102, 3'b010, 32'h0);
    acc_b(32'h100, 3'b011, 32'h0);

    repeat (3) @(posedge clk);
    if (txn_q.size() != 0) begin
      checks++; fails++;
      $display("FAIL txn_queue_drain: got %0d pending, required 0", txn_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/miriscv_lsu_split.md
# miriscv_lsu_split

Next-generation load/store unit for the miriscv core. It sits between the core's memory stage and the data memory port. It replaces the purely combinational single-cycle access with a request/grant/response memory handshake. It also adds hardware splitting of misaligned halfword and word accesses into two aligned word transactions, selectable by parameter.

## Interface
- MISALIGN_EN, default 1: 1 means misaligned accesses are split into two transactions; 0 means misaligned accesses fault without any memory access.
- clk_i  in  1  clock; all state updates on the rising edge.
- arstn_i  in  1  reset; synchronous, active-high.
- lsu_addr_i  in  32  byte address of the access.
- lsu_we_i  in  1  1 selects store, 0 selects load.
- lsu_size_i  in  3  size code: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other code is invalid.
- lsu_data_i  in  32  store data, right-aligned.
- lsu_req_i  in  1  access request; held stable by the core while lsu_stall_req_o=1.
- lsu_stall_req_o  out  1  pipeline stall request.
- lsu_data_o  out  32  load result, sign- or zero-extended.
- lsu_fault_o  out  1  one-cycle pulse: invalid size, or misaligned access with MISALIGN_EN=0.
- data_req_o  out  1  memory request.
- data_gnt_i  in  1  memory accepted the request this cycle.
- data_rvalid_i  in  1  memory response valid; asserted for loads and stores.
- data_rdata_i  in  32  memory read word.
- data_we_o  out  1  memory write enable.
- data_be_o  out  4  byte enables.
- data_addr_o  out  32  word-aligned memory address, bits [1:0]=00.
- data_wdata_o  out  32  lane-shifted write data.

## Operation
- FSM states: IDLE, ADDR1, RESP1, ADDR2, RESP2, DONE.
- IDLE, lsu_req_i=1: latch address, we, size and data.
  - Valid access → ADDR1.
  - Invalid size, or misaligned access with MISALIGN_EN=0 → DONE with fault flag set.
- ADDR1/ADDR2: data_req_o=1 with addr, be, we and wdata held stable. data_gnt_i=1 → RESP1/RESP2. Otherwise stay.
- RESP1, data_rvalid_i=1: capture data_rdata_i as low word. Split access → ADDR2; otherwise → DONE.
- RESP2, data_rvalid_i=1: capture high word → DONE.
- DONE: → IDLE unconditionally.
- Offset o = addr[1:0]. Mask m: B/BU=0001, H/HU=0011, W=1111. Define 8-bit value e = m << o.
- Split condition: e[7:4] != 0, i.e. H/HU with o=3, or W with o≠0.
- Transaction 1: addr = {addr[31:2],00}, be = e[3:0], wdata = lsu_data_i << 8*o.
- Transaction 2: addr = {addr[31:2],00}+4, wrapping mod 2^32; be = e[7:4]; wdata = lsu_data_i >> 8*(4−o).
- Load assembly: 64-bit value {hi,lo} >> 8*o, then take the low 8, 16 or 32 bits. B/H sign-extend; BU/HU zero-extend. For non-split loads hi is don't-care.
- lsu_data_o: register, updated when entering DONE on a valid load; holds its value otherwise, including on stores and faults.
- lsu_fault_o=1 only in DONE when the fault flag is set.

## Timing
- Reset values:
  - state=IDLE.
  - data_req_o=0, data_we_o=0, data_be_o=0000, data_addr_o=0, data_wdata_o=0.
  - lsu_data_o=0, lsu_fault_o=0.
  - lsu_stall_req_o=0 while lsu_req_i=0.
- lsu_stall_req_o = lsu_req_i && state!=DONE, combinational. It asserts in the same cycle as the request and deasserts in DONE, so the core advances on the edge leaving DONE.
- Minimum latency, zero-wait memory (gnt in the first ADDR cycle, rvalid in the first RESP cycle), request seen at cycle 0:
  - Non-split: ADDR1 at cycle 1, RESP1 at 2, DONE at 3. Stall is high in cycles 0–2.
  - Split: DONE at cycle 5.
  - Fault: DONE at cycle 1, no data_req_o.
- Memory outputs are registered. They are valid only in ADDR states; data_req_o=0 in every other state.
- A new request can be accepted in the IDLE cycle immediately after DONE. There is no back-to-back acceptance from DONE itself.
- data_rvalid_i outside RESP states is ignored. data_gnt_i outside ADDR states is ignored.
- arstn_i=1 in any state → IDLE on the next edge, with data_req_o=0. An outstanding response arriving after reset is ignored.

## Test plan
- LW addr 0x100, gnt and rvalid immediate, rdata 0xDEADBEEF → one transaction with addr 0x100, be 1111; lsu_data_o=0xDEADBEEF in DONE at cycle 3.
- LB addr 0x203, rdata 0x80112233 → be 1000, lsu_data_o=0xFFFFFF80. Same access with LBU → 0x00000080.
- SW addr 0x101, data 0xAABBCCDD, MISALIGN_EN=1 → transaction 1: addr 0x100, be 1110, wdata 0xBBCCDD00; transaction 2: addr 0x104, be 0001, wdata low byte 0xAA. DONE at cycle 5.
- LH addr 0x0FFFFFFF (o=3), word@0x0FFFFFFC=0x12xxxxxx, word@0x10000000=0xxxxxxx80 → two reads; lsu_data_o=0xFFFF8012.
- MISALIGN_EN=0, LW addr 0x102 → no data_req_o, lsu_fault_o pulse at cycle 1, lsu_data_o unchanged. Size 011 → same response.
- data_gnt_i withheld 3 cycles, then rvalid after 2 more → request held stable throughout, stall stays high. Assert arstn_i in RESP1 → IDLE next edge, data_req_o=0, stall low once lsu_req_i drops.
